// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified SRAM.
// The arbiter uses the slave modport; the CPU/SRAM side uses master.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_en;
  logic [3:0]        inst_we;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_en;
  logic [3:0]        data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stallreq_arb;

  modport slave (
    input  inst_en, inst_we, inst_addr, inst_wdata,
    output inst_rdata,
    input  data_en, data_we, data_addr, data_wdata,
    output data_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stallreq_arb
  );

  modport master (
    output inst_en, inst_we, inst_addr, inst_wdata,
    input  inst_rdata,
    output data_en, data_we, data_addr, data_wdata,
    input  data_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stallreq_arb
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Data-first arbiter sharing one SRAM between fetch and data ports; replays fetch.
// Optional ARB_PERF_CNT_EN adds conflict and stall-cycle counters.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  sram_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_conflicts,
  output logic [31:0] perf_stall_cycles
`endif
);
  typedef enum logic {S_PASS, S_REPLAY} state_t;
  typedef enum logic [1:0] {
    T_NONE, T_INST, T_DATA
  } tag_t;

  state_t            r_state;
  tag_t              r_tag;
  tag_t              w_tag_nxt;
  logic [3:0]        r_rep_we;
  logic [ADDR_W-1:0] r_rep_addr;
  logic [DATA_W-1:0] r_rep_wdata;
  logic [DATA_W-1:0] r_inst_hold;
  logic [DATA_W-1:0] r_data_hold;
  logic              w_conflict;
  logic              w_sel_rep;
  logic              w_sel_data;
  logic              w_sel_inst;

  assign w_conflict = (r_state == S_PASS)
                    & bus.inst_en & bus.data_en;
  // A reset landing on the replay cycle drops the fetch
  assign w_sel_rep  = (r_state == S_REPLAY) & ~rst_n;
  assign w_sel_data = (r_state == S_PASS) & bus.data_en;
  assign w_sel_inst = (r_state == S_PASS)
                    & ~bus.data_en & bus.inst_en;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    w_tag_nxt     = T_NONE;
    unique case (1'b1)
      w_sel_rep: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_rep_we;
        bus.mem_addr  = r_rep_addr;
        bus.mem_wdata = r_rep_wdata;
        w_tag_nxt = (r_rep_we == 4'h0) ? T_INST : T_NONE;
      end
      w_sel_data: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.data_we;
        bus.mem_addr  = bus.data_addr;
        bus.mem_wdata = bus.data_wdata;
        w_tag_nxt = (bus.data_we == 4'h0) ? T_DATA : T_NONE;
      end
      w_sel_inst: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.inst_we;
        bus.mem_addr  = bus.inst_addr;
        bus.mem_wdata = bus.inst_wdata;
        w_tag_nxt = (bus.inst_we == 4'h0) ? T_INST : T_NONE;
      end
      default: ;
    endcase
  end

  assign bus.stallreq_arb = (r_state == S_REPLAY);
  assign bus.inst_rdata = (r_tag == T_INST) ? bus.mem_rdata
                                            : r_inst_hold;
  assign bus.data_rdata = (r_tag == T_DATA) ? bus.mem_rdata
                                            : r_data_hold;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_PASS;
      r_tag       <= T_NONE;
      r_rep_we    <= 4'h0;
      r_rep_addr  <= '0;
      r_rep_wdata <= '0;
      r_inst_hold <= '0;
      r_data_hold <= '0;
    end else begin
      r_tag <= w_tag_nxt;
      if (r_tag == T_INST) r_inst_hold <= bus.mem_rdata;
      if (r_tag == T_DATA) r_data_hold <= bus.mem_rdata;
      unique case (r_state)
        S_PASS: begin
          if (w_conflict) begin
            r_rep_we    <= bus.inst_we;
            r_rep_addr  <= bus.inst_addr;
            r_rep_wdata <= bus.inst_wdata;
            r_state     <= S_REPLAY;
          end
        end
        S_REPLAY: r_state <= S_PASS;
        default:  r_state <= S_PASS;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_conf;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_perf_conf  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_conflict) r_perf_conf <= r_perf_conf + 32'd1;
      if (r_state == S_REPLAY)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_conflicts    = r_perf_conf;
  assign perf_stall_cycles = r_perf_stall;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural synchronous SRAM.
// Expectations are queued per cycle and checked by an independent monitor.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_c;
  logic [31:0] perf_s;
`endif

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_conflicts   (perf_c),
    .perf_stall_cycles(perf_s)
`endif
  );

  logic [31:0] mem [0:4095];
  logic [31:0] r_rd = 32'd0;
  assign bus.mem_rdata = r_rd;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b])
            mem[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        r_rd <= mem[bus.mem_addr[13:2]];
      end
    end
  end

  typedef enum {
    F_EN, F_ADDR, F_WE, F_WD, F_IRD, F_DRD, F_STALL, F_PC, F_PS
  } fld_e;

  typedef struct {
    int          cyc;
    fld_e        f;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] act(fld_e f);
    case (f)
      F_EN:    return {31'd0, bus.mem_en};
      F_ADDR:  return bus.mem_addr;
      F_WE:    return {28'd0, bus.mem_we};
      F_WD:    return bus.mem_wdata;
      F_IRD:   return bus.inst_rdata;
      F_DRD:   return bus.data_rdata;
      F_STALL: return {31'd0, bus.stallreq_arb};
`ifdef ARB_PERF_CNT_EN
      F_PC:    return perf_c;
      F_PS:    return perf_s;
`endif
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic expect_at(int dc, fld_e f, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.f   = f;
    e.v   = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [31:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        a = act(sb[i].f);
        if (a !== sb[i].v) begin
          errors++;
          $display("FAIL %s cyc %0d got %h want %h",
                   sb[i].nm, cyc, a, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic ie, logic [31:0] ia, logic de,
                       logic [3:0] dwe, logic [31:0] da,
                       logic [31:0] dwd);
    bus.inst_en    = ie;
    bus.inst_we    = 4'h0;
    bus.inst_addr  = ia;
    bus.inst_wdata = 32'd0;
    bus.data_en    = de;
    bus.data_we    = dwe;
    bus.data_addr  = da;
    bus.data_wdata = dwd;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[32'h1000 >> 2] = 32'h00000013;
    mem[32'h1004 >> 2] = 32'h00100093;
    mem[32'h1008 >> 2] = 32'h00200113;
    mem[32'h2000 >> 2] = 32'hDEADBEEF;
    idle();

    tick(); tick();
    expect_at(0, F_EN, 32'd0, "rst_mem_en");
    expect_at(0, F_ADDR, 32'd0, "rst_mem_addr");
    expect_at(0, F_STALL, 32'd0, "rst_stall");
    expect_at(0, F_IRD, 32'd0, "rst_inst_rdata");
    expect_at(0, F_DRD, 32'd0, "rst_data_rdata");
    tick();
    rst_n = 1'b0;

    tick();
    drive(1'b1, 32'h1000, 1'b0, 4'h0, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.mem_en !== 1'b1) begin
      errors++;
      $display("FAIL fetch_mem_en_d got %b", bus.mem_en);
    end
    checks++;
    if (bus.mem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL fetch_mem_addr_d got %h", bus.mem_addr);
    end
    expect_at(0, F_EN, 32'd1, "fetch_mem_en");
    expect_at(0, F_ADDR, 32'h1000, "fetch_mem_addr");
    expect_at(0, F_STALL, 32'd0, "fetch_stall");
    expect_at(1, F_IRD, 32'h13, "fetch_inst_rdata");
    expect_at(1, F_STALL, 32'd0, "fetch_stall_n1");
    for (int k = 2; k <= 4; k++)
      expect_at(k, F_IRD, 32'h13, "hold_inst_rdata");
    for (int k = 2; k <= 4; k++)
      expect_at(k, F_DRD, 32'hDEADBEEF, "hold_data_rdata");
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1'b0, 32'd0, 1'b1, 4'h0, 32'h2000, 32'd0);
      expect_at(0, F_ADDR, 32'h2000, "hold_mem_addr");
    end
    tick();
    idle();

    tick();
    drive(1'b1, 32'h1004, 1'b1, 4'h0, 32'h2000, 32'd0);
    #1;
    checks++;
    if (bus.mem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL conf_mem_addr_d got %h", bus.mem_addr);
    end
    checks++;
    if (bus.stallreq_arb !== 1'b0) begin
      errors++;
      $display("FAIL conf_stall_d got %b", bus.stallreq_arb);
    end
    expect_at(0, F_ADDR, 32'h2000, "conf_mem_addr_n");
    expect_at(0, F_STALL, 32'd0, "conf_stall_n");
    expect_at(1, F_EN, 32'd1, "conf_mem_en_n1");
    expect_at(1, F_ADDR, 32'h1004, "conf_mem_addr_n1");
    expect_at(1, F_DRD, 32'hDEADBEEF, "conf_data_rdata_n1");
    expect_at(1, F_IRD, 32'h13, "conf_inst_hold_n1");
    expect_at(1, F_STALL, 32'd1, "conf_stall_n1");
    expect_at(2, F_IRD, 32'h00100093, "conf_inst_rdata_n2");
    expect_at(2, F_DRD, 32'hDEADBEEF, "conf_data_hold_n2");
    expect_at(2, F_STALL, 32'd0, "conf_stall_n2");
    expect_at(2, F_EN, 32'd0, "conf_mem_en_n2");
    tick();
    drive(1'b0, 32'd0, 1'b1, 4'h0, 32'h3000, 32'd0);
    tick();
    idle();

    tick();
    drive(1'b1, 32'h1008, 1'b1, 4'hF, 32'h2000, 32'h55);
    expect_at(0, F_WE, 32'hF, "st_mem_we");
    expect_at(0, F_ADDR, 32'h2000, "st_mem_addr");
    expect_at(0, F_WD, 32'h55, "st_mem_wdata");
    expect_at(1, F_ADDR, 32'h1008, "st_replay_addr");
    expect_at(1, F_WE, 32'h0, "st_replay_we");
    expect_at(1, F_STALL, 32'd1, "st_stall");
    expect_at(1, F_DRD, 32'hDEADBEEF, "st_data_unchanged");
    expect_at(2, F_IRD, 32'h00200113, "st_inst_rdata");
    expect_at(2, F_DRD, 32'hDEADBEEF, "st_data_unchanged2");
    expect_at(2, F_ADDR, 32'h2000, "st_load_addr");
    expect_at(3, F_DRD, 32'h55, "st_load_back");
    tick();
    idle();
    tick();
    drive(1'b0, 32'd0, 1'b1, 4'h0, 32'h2000, 32'd0);
    tick();
    idle();

    tick();
    drive(1'b1, 32'h1000, 1'b1, 4'h0, 32'h2000, 32'd0);
    expect_at(0, F_STALL, 32'd0, "b2b_stall0");
    expect_at(0, F_ADDR, 32'h2000, "b2b_addr0");
    expect_at(1, F_STALL, 32'd1, "b2b_stall1");
    expect_at(1, F_ADDR, 32'h1000, "b2b_addr1");
    expect_at(1, F_DRD, 32'h55, "b2b_drd1");
    expect_at(2, F_STALL, 32'd0, "b2b_stall2");
    expect_at(2, F_ADDR, 32'h2000, "b2b_addr2");
    expect_at(2, F_IRD, 32'h13, "b2b_ird2");
    expect_at(3, F_STALL, 32'd1, "b2b_stall3");
    expect_at(3, F_ADDR, 32'h1000, "b2b_addr3");
    expect_at(4, F_STALL, 32'd0, "b2b_stall4");
    expect_at(4, F_EN, 32'd0, "b2b_en4");
    expect_at(4, F_IRD, 32'h13, "b2b_ird4");
    tick(); tick(); tick();
    idle();
    tick(); tick();

    drive(1'b1, 32'h1004, 1'b1, 4'h0, 32'h2000, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    expect_at(0, F_STALL, 32'd1, "rr_stall_in_replay");
    expect_at(0, F_EN, 32'd0, "rr_fetch_dropped");
    tick();
    rst_n = 1'b0;
    expect_at(0, F_EN, 32'd0, "rr_mem_en");
    expect_at(0, F_STALL, 32'd0, "rr_stall");
    expect_at(0, F_IRD, 32'd0, "rr_inst_rdata");
    expect_at(0, F_DRD, 32'd0, "rr_data_rdata");
    tick();

`ifdef ARB_PERF_CNT_EN
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 32'h1000, 1'b1, 4'h0, 32'h2000, 32'd0);
      tick();
      idle();
      tick(); tick();
    end
    expect_at(0, F_PC, 32'd5, "perf_conflicts");
    expect_at(0, F_PS, 32'd5, "perf_stall_cycles");
    tick();
`endif

    tick(); tick(); tick();
    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s expired at cyc %0d", sb[i].nm, sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the CPU's instruction fetch port and data access port. It sits between the pipeline's `inst_sram_*`/`data_sram_*` buses and a unified memory. It resolves same-cycle conflicts with data-first priority and replays the losing fetch. It raises a stall request to the pipeline controller while the fetch is being replayed.

## Interface
- `ADDR_W`, default 32: address width of all ports.
- `DATA_W`, default 32: data width of all ports.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous, active-high reset. The block is in reset while `rst_n` = 1. The name is kept for top-level consistency.
- `inst_en`, `inst_we`, `inst_addr`, `inst_wdata` in 1/4/ADDR_W/DATA_W: instruction request.
- `inst_rdata` out DATA_W: instruction read data.
- `data_en`, `data_we`, `data_addr`, `data_wdata` in 1/4/ADDR_W/DATA_W: data request.
- `data_rdata` out DATA_W: data read data.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` out 1/4/ADDR_W/DATA_W: unified SRAM request.
- `mem_rdata` in DATA_W: SRAM read data, valid one cycle after `mem_en`.
- `stallreq_arb` out 1: freeze request to the pipeline controller.

## Operation
- State machine:
  - PASS: reset state.
  - REPLAY: entered from PASS on a conflict, meaning `inst_en` & `data_en` in the same cycle.
  - REPLAY always returns to PASS after exactly one cycle.
- PASS behaviour:
  - If `data_en` is high, drive `mem_*` from the data port.
  - Otherwise, if `inst_en` is high, drive `mem_*` from the inst port.
  - Otherwise `mem_en` = 0 and the other `mem_*` outputs = 0.
  - On a conflict, capture `inst_addr`, `inst_we` and `inst_wdata` into the replay register and go to REPLAY.
- REPLAY behaviour:
  - Drive `mem_*` from the replay register with `mem_en` = 1.
  - CPU ports are ignored.
  - `stallreq_arb` = 1, combinational from the state.
- Grant tag: a registered field of NONE, INST or DATA, recording who owned the port last cycle. Only reads are tagged; a request with `mem_we` ≠ 0 tags NONE.
- Read routing:
  - If the tag is INST, `inst_rdata` = `mem_rdata` and the inst hold register loads `mem_rdata`.
  - If the tag is DATA, the same applies to `data_rdata` and the data hold register.
  - A non-tagged port outputs its hold register, so read data stays stable across stalls.
- Stores: pass through unchanged and leave both hold registers unchanged.
- Reset values: state PASS, tag NONE, replay register 0, both hold registers 0. `inst_rdata` = `data_rdata` = 0, `stallreq_arb` = 0, all `mem_*` outputs = 0 (with no request present).
- Reset mid-REPLAY: the pending fetch is dropped with no `mem_en` issued for it, and the next cycle is PASS.

## Timing
- No conflict: request in cycle N goes out on `mem_*` in cycle N, and read data appears on the port in cycle N+1. This is zero added latency.
- Conflict in cycle N:
  - Data is issued in N and its read data appears in N+1.
  - The fetch is issued in N+1 with `stallreq_arb` = 1 in N+1, and its read data appears in N+2.
- `stallreq_arb` is high for exactly one cycle per conflict. Back-to-back conflicts give alternating PASS and REPLAY, so the fetch is never starved.
- `mem_*` outputs and `stallreq_arb` are combinational from the state, the replay register and the port inputs. No combinational path runs from `mem_rdata` to `mem_*`.

## Configuration
- `ARB_PERF_CNT_EN` defined:
  - Adds 32-bit outputs `perf_conflicts` (counts PASS→REPLAY transitions) and `perf_stall_cycles` (counts cycles with `stallreq_arb` = 1).
  - Both are cleared by reset and wrap at 2^32 with no saturation.
- `ARB_PERF_CNT_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Fetch only: `inst_en` = 1, addr 0x1000, memory holds 0x00000013 → `mem_addr` = 0x1000 in the same cycle, `inst_rdata` = 0x13 next cycle, `stallreq_arb` stays 0.
- Conflict: inst 0x1004 and data load 0x2000 (holding 0xDEADBEEF) in cycle N → cycle N `mem_addr` = 0x2000. Cycle N+1: `mem_addr` = 0x1004, `data_rdata` = 0xDEADBEEF, `stallreq_arb` = 1. Cycle N+2: `inst_rdata` = memory[0x1004], `stallreq_arb` = 0.
- Store/fetch conflict: data `we` = 0xF, addr 0x2000, wdata 0x55 with inst 0x1008 → write issued first, fetch replayed, `data_rdata` unchanged, subsequent load of 0x2000 returns 0x55.
- Hold: after the inst read of 0x13, issue data reads for 3 cycles → `inst_rdata` stays 0x13 throughout.
- Reset mid-REPLAY: assert `rst_n` in the REPLAY cycle → next cycle `mem_en` = 0, `stallreq_arb` = 0, both rdata outputs = 0.
- With `ARB_PERF_CNT_EN`: 5 conflicts separated by idle cycles → `perf_conflicts` = 5 and `perf_stall_cycles` = 5.
